report_sequencer: RTL and testbench

Post-simulation statistics controller that sits between `manager` and `network`. On a start pulse it walks every PE address, then every link address, and handshakes each element's report out of the network. It accumulates packet count, packet-weighted latency and link energy. It finishes by pulsing `report_rs` to clear the network's statistics, then signals completion.

---
 rtl/report_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_report_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/report_sequencer.sv
// Post-simulation statistics scanner: walks every PE then every link, handshakes each report
// out of the network, accumulates packet/latency/energy totals, then clears the network stats.
module report_sequencer #(
   parameter int cluster_first_dimension_up_bound      = 7,
   parameter int cluster_second_dimension_up_bound     = 6,
   parameter int cluster_first_dimension_no_addr_bits  = 3,
   parameter int cluster_second_dimension_no_addr_bits = 3,
   parameter int addr_length                           = 6,
   parameter int no_links                              = 194,
   parameter int link_addr_length                      = 11,
   parameter int timeout_cycles                        = 255
) (
   input  logic                        clk,
   input  logic                        full_rs,
   input  logic                        start,
   input  logic                        busy,
   input  logic [31:0]                 averge_time_of_flies,
   input  logic [31:0]                 no_packet_recieve,
   input  logic [63:0]                 link_energy_consumption,
   output logic [addr_length-1:0]      pe_addr_called,
   output logic [link_addr_length-1:0] link_addr_called,
   output logic                        pe_report_en,
   output logic                        report_rs,
   output logic                        scanning,
   output logic                        done,
   output logic [31:0]                 total_packets,
   output logic [63:0]                 latency_sum,
   output logic [63:0]                 total_energy,
   output logic                        overflow,
   output logic                        timeout_err
);

   localparam int XW     = cluster_first_dimension_no_addr_bits;
   localparam int YW     = cluster_second_dimension_no_addr_bits;
   localparam int WAIT_W = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
   localparam logic [XW-1:0] X_UP = XW'(cluster_first_dimension_up_bound);
   localparam logic [YW-1:0] Y_UP = YW'(cluster_second_dimension_up_bound);
   localparam logic [link_addr_length-1:0] LINK_LAST =
      link_addr_length'((no_links > 0) ? no_links - 1 : 0);
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      WAIT_W'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);
   localparam bit HAS_LINKS = (no_links > 0);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PE_REQ    = 3'd1,
      PE_WAIT   = 3'd2,
      LINK_REQ  = 3'd3,
      LINK_WAIT = 3'd4,
      CLEAR     = 3'd5,
      DONE      = 3'd6
   } state_e;

   state_e                      state_q, state_d;
   logic [XW-1:0]               x_q, x_d;
   logic [YW-1:0]               y_q, y_d;
   logic [link_addr_length-1:0] link_q, link_d;
   logic [WAIT_W-1:0]           wait_q, wait_d;
   logic [addr_length-1:0]      pe_addr_q, pe_addr_d;
   logic [link_addr_length-1:0] link_addr_q, link_addr_d;
   logic                        pe_report_en_q, pe_report_en_d;
   logic                        report_rs_q, report_rs_d;
   logic                        scanning_q, scanning_d;
   logic                        done_q, done_d;
   logic [31:0]                 total_packets_q, total_packets_d;
   logic [63:0]                 latency_sum_q, latency_sum_d;
   logic [63:0]                 total_energy_q, total_energy_d;
   logic                        overflow_q, overflow_d;
   logic                        timeout_err_q, timeout_err_d;

   logic [32:0] pkt_sum;
   logic [63:0] product;
   logic [64:0] lat_sum;
   logic [64:0] en_sum;
   logic        elem_done;

   // Handshake: outputs are registered from the current state, so the network sees
   // pe_report_en and the address in the first WAIT cycle; an element completes on the first
   // WAIT cycle with busy low (data sampled then) or after timeout_cycles busy WAIT cycles.
   always_comb begin
      state_d         = state_q;
      x_d             = x_q;
      y_d             = y_q;
      link_d          = link_q;
      wait_d          = wait_q;
      pe_addr_d       = pe_addr_q;
      link_addr_d     = link_addr_q;
      pe_report_en_d  = (state_q == PE_REQ) || (state_q == LINK_REQ);
      report_rs_d     = (state_q == CLEAR);
      done_d          = (state_q == DONE);
      scanning_d      = done_q ? 1'b0 : scanning_q;
      total_packets_d = total_packets_q;
      latency_sum_d   = latency_sum_q;
      total_energy_d  = total_energy_q;
      overflow_d      = overflow_q;
      timeout_err_d   = timeout_err_q;

      pkt_sum   = {1'b0, total_packets_q} + {1'b0, no_packet_recieve};
      product   = 64'(averge_time_of_flies) * 64'(no_packet_recieve);
      lat_sum   = {1'b0, latency_sum_q} + {1'b0, product};
      en_sum    = {1'b0, total_energy_q} + {1'b0, link_energy_consumption};
      elem_done = !busy || (wait_q == WAIT_LAST);

      case (state_q)
         IDLE: begin
            if (start) begin
               x_d             = '0;
               y_d             = '0;
               link_d          = '0;
               total_packets_d = '0;
               latency_sum_d   = '0;
               total_energy_d  = '0;
               overflow_d      = 1'b0;
               timeout_err_d   = 1'b0;
               scanning_d      = 1'b1;
               state_d         = PE_REQ;
            end
         end
         PE_REQ: begin
            pe_addr_d = addr_length'({y_q, x_q});
            wait_d    = '0;
            state_d   = PE_WAIT;
         end
         PE_WAIT: begin
            if (elem_done) begin
               if (!busy) begin
                  total_packets_d = pkt_sum[31:0];
                  latency_sum_d   = lat_sum[63:0];
                  overflow_d      = overflow_q | pkt_sum[32] | lat_sum[64];
               end else begin
                  timeout_err_d = 1'b1;
               end
               if (x_q == X_UP) begin
                  x_d = '0;
                  if (y_q == Y_UP) begin
                     state_d = HAS_LINKS ? LINK_REQ : CLEAR;
                  end else begin
                     y_d     = y_q + 1'b1;
                     state_d = PE_REQ;
                  end
               end else begin
                  x_d     = x_q + 1'b1;
                  state_d = PE_REQ;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         LINK_REQ: begin
            link_addr_d = link_q;
            wait_d      = '0;
            state_d     = LINK_WAIT;
         end
         LINK_WAIT: begin
            if (elem_done) begin
               if (!busy) begin
                  total_energy_d = en_sum[63:0];
                  overflow_d     = overflow_q | en_sum[64];
               end else begin
                  timeout_err_d = 1'b1;
               end
               if (link_q == LINK_LAST) begin
                  state_d = CLEAR;
               end else begin
                  link_d  = link_q + 1'b1;
                  state_d = LINK_REQ;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         CLEAR:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (full_rs) begin
         state_q         <= IDLE;
         x_q             <= '0;
         y_q             <= '0;
         link_q          <= '0;
         wait_q          <= '0;
         pe_addr_q       <= '0;
         link_addr_q     <= '0;
         pe_report_en_q  <= 1'b0;
         report_rs_q     <= 1'b0;
         scanning_q      <= 1'b0;
         done_q          <= 1'b0;
         total_packets_q <= '0;
         latency_sum_q   <= '0;
         total_energy_q  <= '0;
         overflow_q      <= 1'b0;
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         x_q             <= x_d;
         y_q             <= y_d;
         link_q          <= link_d;
         wait_q          <= wait_d;
         pe_addr_q       <= pe_addr_d;
         link_addr_q     <= link_addr_d;
         pe_report_en_q  <= pe_report_en_d;
         report_rs_q     <= report_rs_d;
         scanning_q      <= scanning_d;
         done_q          <= done_d;
         total_packets_q <= total_packets_d;
         latency_sum_q   <= latency_sum_d;
         total_energy_q  <= total_energy_d;
         overflow_q      <= overflow_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   assign pe_addr_called   = pe_addr_q;
   assign link_addr_called = link_addr_q;
   assign pe_report_en     = pe_report_en_q;
   assign report_rs        = report_rs_q;
   assign scanning         = scanning_q;
   assign done             = done_q;
   assign total_packets    = total_packets_q;
   assign latency_sum      = latency_sum_q;
   assign total_energy     = total_energy_q;
   assign overflow         = overflow_q;
   assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_report_sequencer.sv
// Directed bench for report_sequencer: the bench plays the network, a queue holds the expected
// request order, and each scan ends with timing and total checks.
module tb_report_sequencer;

   localparam int NPE = 56;
   localparam int NL  = 194;

   logic        clk = 1'b0;
   logic        full_rs;
   logic        start;
   logic        busy;
   logic [31:0] averge_time_of_flies;
   logic [31:0] no_packet_recieve;
   logic [63:0] link_energy_consumption;
   logic [5:0]  pe_addr_called;
   logic [10:0] link_addr_called;
   logic        pe_report_en;
   logic        report_rs;
   logic        scanning;
   logic        done;
   logic [31:0] total_packets;
   logic [63:0] latency_sum;
   logic [63:0] total_energy;
   logic        overflow;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_q[$];

   report_sequencer dut (
      .clk                     (clk),
      .full_rs                 (full_rs),
      .start                   (start),
      .busy                    (busy),
      .averge_time_of_flies    (averge_time_of_flies),
      .no_packet_recieve       (no_packet_recieve),
      .link_energy_consumption (link_energy_consumption),
      .pe_addr_called          (pe_addr_called),
      .link_addr_called        (link_addr_called),
      .pe_report_en            (pe_report_en),
      .report_rs               (report_rs),
      .scanning                (scanning),
      .done                    (done),
      .total_packets           (total_packets),
      .latency_sum             (latency_sum),
      .total_energy            (total_energy),
      .overflow                (overflow),
      .timeout_err             (timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end of run, expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_state"}, 64'(dut.state_q), 64'd0);
      check({tag, "_pe_addr"}, 64'(pe_addr_called), 64'd0);
      check({tag, "_link_addr"}, 64'(link_addr_called), 64'd0);
      check({tag, "_strobes"}, 64'({pe_report_en, report_rs, done, scanning}), 64'd0);
      check({tag, "_packets"}, 64'(total_packets), 64'd0);
      check({tag, "_latency"}, latency_sum, 64'd0);
      check({tag, "_energy"}, total_energy, 64'd0);
      check({tag, "_flags"}, 64'({overflow, timeout_err}), 64'd0);
   endtask

   // One scan. stall_addr: PE held busy for stall_len cycles; stuck_addr: PE busy until the next
   // request; late_cyc: cycle of a spurious start; rst_link: link at which full_rs is pulsed.
   task automatic run_scan(input string name, input int stall_addr, input int stall_len,
                           input int stuck_addr, input int late_cyc, input int rst_link,
                           input logic [63:0] energy_val, input logic [31:0] exp_pk,
                           input logic [63:0] exp_lat, input logic [63:0] exp_en,
                           input logic exp_ovf, input logic exp_to, input int exp_rs_cyc);
      int   nstrobe = 0;
      int   rs_cnt = 0, rs_cyc = 0, done_cnt = 0, done_cyc = 0;
      int   busy_left = 0, stall_cyc = 0, cur_addr, pulses;
      logic cur_pe, stuck_on = 1'b0, scan_ok = 1'b1;
      logic [11:0] obs, expv;

      exp_q.delete();
      for (int y = 0; y < 7; y++)
         for (int x = 0; x < 8; x++)
            exp_q.push_back({1'b1, 5'd0, 6'(y * 8 + x)});
      for (int j = 0; j < NL; j++) exp_q.push_back({1'b0, 11'(j)});

      busy = 1'b0;
      averge_time_of_flies = 32'd10;
      no_packet_recieve = 32'd2;
      link_energy_consumption = energy_val;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;

      for (int cyc = 1; cyc <= 1500; cyc++) begin
         if (done_cnt > 0 && cyc > done_cyc) begin
            check({name, "_scanning_after_done"}, 64'(scanning), 64'd0);
            break;
         end
         if (done_cnt == 0 && !scanning) scan_ok = 1'b0;
         if (report_rs) begin rs_cnt++; rs_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (pe_report_en) begin
            cur_pe = (nstrobe < NPE);
            nstrobe++;
            obs = cur_pe ? {1'b1, 5'd0, pe_addr_called} : {1'b0, link_addr_called};
            cur_addr = cur_pe ? int'(pe_addr_called) : int'(link_addr_called);
            if (exp_q.size() == 0) begin
               check({name, "_strobe_overrun"}, 64'(nstrobe), 64'(NPE + NL));
            end else begin
               expv = exp_q.pop_front();
               check({name, "_addr_order"}, 64'(obs), 64'(expv));
            end
            if (cur_pe && stall_cyc > 0 && cur_addr == stall_addr + 1)
               check({name, "_stall_gap"}, 64'(cyc - stall_cyc), 64'(stall_len + 2));
            if (cur_pe && cur_addr == stall_addr) begin
               busy_left = stall_len;
               stall_cyc = cyc;
            end
            stuck_on = cur_pe && (cur_addr == stuck_addr);
            if (!cur_pe && exp_ovf && cur_addr == 1)
               check({name, "_ovf_after_1_link"}, 64'(overflow), 64'd0);
            if (!cur_pe && exp_ovf && cur_addr == 2)
               check({name, "_ovf_after_2_links"}, 64'(overflow), 64'd1);
            if (!cur_pe && cur_addr == rst_link) begin
               full_rs = 1'b1;
               @(negedge clk) full_rs = 1'b0;
               check_zero({name, "_midscan_rst"});
               pulses = 0;
               for (int k = 0; k < 600; k++) begin
                  @(negedge clk);
                  if (report_rs || done || pe_report_en) pulses++;
               end
               check({name, "_pulses_after_rst"}, 64'(pulses), 64'd0);
               exp_q.delete();
               return;
            end
         end
         start = (cyc == late_cyc);
         if (busy_left > 0) begin
            busy = 1'b1;
            busy_left--;
         end else begin
            busy = stuck_on;
         end
         averge_time_of_flies = busy ? 32'd77 : 32'd10;
         no_packet_recieve = busy ? 32'd1000 : 32'd2;
         @(negedge clk);
      end
      start = 1'b0;
      busy = 1'b0;

      check({name, "_done_count"}, 64'(done_cnt), 64'd1);
      check({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_rs_cyc + 1));
      check({name, "_report_rs_count"}, 64'(rs_cnt), 64'd1);
      check({name, "_report_rs_cycle"}, 64'(rs_cyc), 64'(exp_rs_cyc));
      check({name, "_scanning_window"}, 64'(scan_ok), 64'd1);
      check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
      check({name, "_total_packets"}, 64'(total_packets), 64'(exp_pk));
      check({name, "_latency_sum"}, latency_sum, exp_lat);
      check({name, "_total_energy"}, total_energy, exp_en);
      check({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
      check({name, "_timeout_err"}, 64'(timeout_err), 64'(exp_to));
   endtask

   initial begin
      full_rs = 1'b1;
      start = 1'b0;
      busy = 1'b0;
      averge_time_of_flies = '0;
      no_packet_recieve = '0;
      link_energy_consumption = '0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_zero("reset");
         start = 1'($urandom_range(0, 1));
         busy = 1'($urandom_range(0, 1));
         averge_time_of_flies = $urandom;
         no_packet_recieve = $urandom;
         link_energy_consumption = {$urandom, $urandom};
      end
      full_rs = 1'b0;
      start = 1'b0;
      busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_zero("idle");
      end

      run_scan("full", -1, 0, -1, -1, -1, 64'd5, 32'd112, 64'd1120, 64'd970, 1'b0, 1'b0, 502);
      repeat (4) @(negedge clk);
      check("hold_packets", 64'(total_packets), 64'd112);
      run_scan("stall", 15, 3, -1, -1, -1, 64'd5, 32'd112, 64'd1120, 64'd970, 1'b0, 1'b0, 505);
      run_scan("timeout", -1, 0, 5, -1, -1, 64'd5, 32'd110, 64'd1100, 64'd970, 1'b0, 1'b1, 756);
      run_scan("late_start", -1, 0, -1, 100, -1, 64'd5, 32'd112, 64'd1120, 64'd970, 1'b0, 1'b0,
               502);
      run_scan("overflow", -1, 0, -1, -1, -1, 64'h8000_0000_0000_0000, 32'd112, 64'd1120,
               64'd0, 1'b1, 1'b0, 502);
      run_scan("midrst", -1, 0, -1, -1, 20, 64'd5, 32'd0, 64'd0, 64'd0, 1'b0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
